ctr_multicycle: RTL and testbench
=================================

Name: ctr_multicycle

Overview:
- Multi-cycle successor to the single-cycle main control decoder: a Moore/Mealy FSM that sequences each MIPS instruction through fetch, decode, execute, memory and writeback steps.
- Drives datapath enables and muxes from opCode, handshakes with a shared instruction/data memory via memReq/memAck, and detects memory timeouts.
- Counts retired instructions.
- Sits between the IR/memory port and the multi-cycle datapath.

Parameters:
- ALUOP_W, 2, aluop width; codes are zero-extended to this width (must be >= 2).
- MEM_TIMEOUT, 16, max cycles waiting for memAck before fault; 0 disables the timeout.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opCode  in  6  IR[31:26]; sampled in DECODE.
- memAck  in  1  memory completes the current access this cycle.
- memReq  out  1  equals memRead|memWrite.
- memRead  out  1  memory read.
- memWrite  out  1  memory write.
- iorD  out  1  0 = PC address, 1 = ALUOut address.
- irWrite  out  1  load IR.
- pcWrite  out  1  unconditional PC write.
- pcWriteCond  out  1  PC write if ALU zero (beq).
- pcSrc  out  2  00 ALU, 01 ALUOut, 10 jump target.
- aluSrcA  out  1  0 = PC, 1 = regA.
- aluSrcB  out  2  00 regB, 01 const 4, 10 signext imm, 11 shifted imm.
- aluop  out  ALUOP_W  00 add, 01 sub, 10 funct, 11 OR.
- regDst  out  1  1 = rd, 0 = rt.
- memToReg  out  1  1 = MDR, 0 = ALUOut.
- regWrite  out  1  register file write.
- instrDone  out  1  one-cycle pulse on instruction retire.
- illegalOp  out  1  one-cycle pulse on an unsupported opcode.
- memTimeout  out  1  sticky fault flag; cleared only by reset.
- instrCount  out  CNT_W  count of retired instructions; wraps to 0.

Behaviour:
- Reset: state = IDLE, opLatch = 0, wait counter = 0, instrCount = 0, memTimeout = 0. Every output is 0 in IDLE. Reset asserted mid-instruction abandons it with no retire.
- All outputs not listed for a state are 0.
- IDLE: -> FETCH unconditionally, unless memTimeout = 1, in which case stay in IDLE.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluop=00, pcSrc=00.
  - irWrite and pcWrite = memAck (Mealy).
  - memAck -> DECODE; otherwise stay.
- DECODE: aluSrcA=0, aluSrcB=11, aluop=00. Latch opCode into opLatch.
  - 100011 / 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP.
  - Immediate opcodes: see Optional Feature.
  - Anything else -> ILLEGAL.
- MEMADR: aluSrcA=1, aluSrcB=10, aluop=00. opLatch 100011 -> MEMRD, else -> MEMWR.
- MEMRD: memRead=1, iorD=1. memAck -> MEMWB; otherwise stay.
- MEMWB: regDst=0, memToReg=1, regWrite=1. Retire; -> FETCH.
- MEMWR: memWrite=1, iorD=1. memAck -> retire, -> FETCH.
- EXEC: aluSrcA=1, aluSrcB=00, aluop=10. -> RWB.
- RWB: regDst=1, regWrite=1. Retire; -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluop=01, pcWriteCond=1, pcSrc=01. Retire; -> FETCH.
- JUMP: pcWrite=1, pcSrc=10. Retire; -> FETCH.
- ILLEGAL: illegalOp=1. No retire; -> FETCH.
- Retire: instrDone=1 for that cycle; instrCount increments on the same edge and wraps from all-ones to 0.
- Latency in cycles, zero-wait memory: j 3, beq 3, R 4, sw 4, lw 5.
- Wait counter: increments on each cycle in FETCH/MEMRD/MEMWR with memAck=0; clears on memAck or on leaving the state.
  - MEM_TIMEOUT > 0 and counter reaches MEM_TIMEOUT-1 with memAck still 0: set memTimeout, force -> IDLE, no retire.
  - memAck in that same cycle wins; no fault.

Optional Feature:
- Macro: CTR_IMM_EN.
- Defined: DECODE maps 001000 (addi) and 001101 (ori) -> IEXEC.
  - IEXEC: aluSrcA=1, aluSrcB=10, aluop = 00 (addi) or 11 (ori). -> IWB.
  - IWB: regDst=0, memToReg=0, regWrite=1. Retire; -> FETCH.
- Undefined: IEXEC/IWB are absent; both opcodes go to ILLEGAL.

Test Plan:
- Reset 3 cycles, then memAck=1 permanently, opCode=000000 -> IDLE 1 cycle; FETCH irWrite=1; EXEC aluop=10; RWB regWrite=1, regDst=1; instrDone at cycle 5; instrCount=1.
- opCode=100011, memAck delayed 2 cycles in MEMRD -> memRead held 3 cycles with iorD=1; MEMWB memToReg=1, regWrite=1; no early retire.
- opCode=000100 then 000010 -> BRANCH shows pcWriteCond=1, pcSrc=01, aluop=01; JUMP shows pcWrite=1, pcSrc=10; instrCount=2.
- opCode=111111 -> illegalOp pulses once; instrCount unchanged; next state FETCH.
- MEM_TIMEOUT=4, memAck=0 in FETCH -> memTimeout=1 after 4 FETCH cycles; FSM parks in IDLE with outputs 0 until reset.
- CNT_W=2, 4 retired j instructions -> instrCount wraps 3 -> 0. With CTR_IMM_EN, opCode=001101 -> aluop=11, then regWrite=1 with memToReg=0.

Source files
------------

// File: rtl/ctr_multicycle.sv
// ctr_multicycle: multi-cycle MIPS main control FSM.
// Steps each instruction through FETCH / DECODE / execute / memory / writeback,
// drives datapath enables and mux selects, handshakes with a shared memory via
// memReq/memAck, raises a sticky memTimeout fault and counts retired instructions.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opCode            IR[31:26], sampled in DECODE
//   memAck            memory completes the current access this cycle
//   memReq/memRead/memWrite/iorD          memory port controls
//   irWrite/pcWrite/pcWriteCond/pcSrc     IR and PC update controls
//   aluSrcA/aluSrcB/aluop                 ALU operand and operation selects
//   regDst/memToReg/regWrite              register file writeback controls
//   instrDone         one-cycle retire pulse
//   illegalOp         one-cycle pulse on an unsupported opcode
//   memTimeout        sticky memory timeout fault, cleared only by reset
//   instrCount        retired-instruction counter, wraps to 0
//
// Build option: define CTR_IMM_EN to add addi/ori support (IEXEC/IWB states);
// without it those opcodes decode as illegal.

module ctr_multicycle #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  input  logic               memAck,
  output logic               memReq,
  output logic               memRead,
  output logic               memWrite,
  output logic               iorD,
  output logic               irWrite,
  output logic               pcWrite,
  output logic               pcWriteCond,
  output logic [1:0]         pcSrc,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [ALUOP_W-1:0] aluop,
  output logic               regDst,
  output logic               memToReg,
  output logic               regWrite,
  output logic               instrDone,
  output logic               illegalOp,
  output logic               memTimeout,
  output logic [CNT_W-1:0]   instrCount
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_MEMADR  = 4'd3;
  localparam logic [3:0] S_MEMRD   = 4'd4;
  localparam logic [3:0] S_MEMWB   = 4'd5;
  localparam logic [3:0] S_MEMWR   = 4'd6;
  localparam logic [3:0] S_EXEC    = 4'd7;
  localparam logic [3:0] S_RWB     = 4'd8;
  localparam logic [3:0] S_BRANCH  = 4'd9;
  localparam logic [3:0] S_JUMP    = 4'd10;
  localparam logic [3:0] S_ILLEGAL = 4'd11;
`ifdef CTR_IMM_EN
  localparam logic [3:0] S_IEXEC   = 4'd12;
  localparam logic [3:0] S_IWB     = 4'd13;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Wait counter only needs to reach MEM_TIMEOUT-1.
  localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  logic [3:0]        state, nextState;
  logic [5:0]        opLatch;
  logic [WCNT_W-1:0] waitCnt;
  logic [1:0]        aluCode;
  logic              retire;
  logic              waiting;
  logic              timeoutHit;

  assign waiting    = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !memAck;
  assign timeoutHit = waiting && (MEM_TIMEOUT > 0) && (waitCnt == WAIT_LAST);

  always_comb begin
    nextState   = state;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    iorD        = 1'b0;
    irWrite     = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSrc       = 2'b00;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluCode     = 2'b00;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    retire      = 1'b0;
    illegalOp   = 1'b0;

    case (state)
      S_IDLE: begin
        if (!memTimeout) nextState = S_FETCH;
      end
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = memAck;
        pcWrite = memAck;
        if (memAck) nextState = S_DECODE;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        case (opCode)
          OP_LW, OP_SW: nextState = S_MEMADR;
          OP_RTYPE:     nextState = S_EXEC;
          OP_BEQ:       nextState = S_BRANCH;
          OP_J:         nextState = S_JUMP;
`ifdef CTR_IMM_EN
          OP_ADDI, OP_ORI: nextState = S_IEXEC;
`endif
          default:      nextState = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        nextState = (opLatch == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        iorD    = 1'b1;
        if (memAck) nextState = S_MEMWB;
      end
      S_MEMWB: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        iorD     = 1'b1;
        if (memAck) begin
          retire    = 1'b1;
          nextState = S_FETCH;
        end
      end
      S_EXEC: begin
        aluSrcA   = 1'b1;
        aluCode   = 2'b10;
        nextState = S_RWB;
      end
      S_RWB: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluCode     = 2'b01;
        pcWriteCond = 1'b1;
        pcSrc       = 2'b01;
        retire      = 1'b1;
        nextState   = S_FETCH;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSrc     = 2'b10;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
      S_ILLEGAL: begin
        illegalOp = 1'b1;
        nextState = S_FETCH;
      end
`ifdef CTR_IMM_EN
      S_IEXEC: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        aluCode   = (opLatch == OP_ORI) ? 2'b11 : 2'b00;
        nextState = S_IWB;
      end
      S_IWB: begin
        regWrite  = 1'b1;
        retire    = 1'b1;
        nextState = S_FETCH;
      end
`endif
      default: nextState = S_IDLE;
    endcase

    // A timeout overrides the stay-and-wait transition; memAck in the same
    // cycle clears waiting, so a late ack still wins.
    if (timeoutHit) nextState = S_IDLE;

    memReq = memRead | memWrite;
  end

  assign aluop     = ALUOP_W'(aluCode);
  assign instrDone = retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      opLatch    <= '0;
      waitCnt    <= '0;
      instrCount <= '0;
      memTimeout <= 1'b0;
    end else begin
      state <= nextState;
      if (state == S_DECODE) opLatch <= opCode;
      if (timeoutHit) memTimeout <= 1'b1;
      if (waiting && !timeoutHit) waitCnt <= waitCnt + 1'b1;
      else                        waitCnt <= '0;
      if (retire) instrCount <= instrCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctr_multicycle.sv
// Directed bench for ctr_multicycle (MEM_TIMEOUT=4, CNT_W=2).
// Each step pushes the expected output vector, counter and fault flag for one
// FSM cycle to a scoreboard queue; the sampled DUT outputs are popped against it.

module tb_ctr_multicycle;

  localparam int TO   = 4;
  localparam int CW   = 2;

  localparam int T_IDLE = 0, T_FETCH = 1, T_DECODE = 2, T_MEMADR = 3, T_MEMRD = 4,
                 T_MEMWB = 5, T_MEMWR = 6, T_EXEC = 7, T_RWB = 8, T_BRANCH = 9,
                 T_JUMP = 10, T_ILLEGAL = 11, T_IEXEC = 12, T_IWB = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opCode;
  logic          memAck;
  logic          memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond;
  logic [1:0]    pcSrc, aluSrcB, aluop;
  logic          aluSrcA, regDst, memToReg, regWrite, instrDone, illegalOp, memTimeout;
  logic [CW-1:0] instrCount;

  typedef struct {
    logic [18:0]   ctl;
    logic [CW-1:0] cnt;
    logic          tmo;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            cycNo = 0;
  logic [CW-1:0] expCnt;
  logic          expTmo;
  int            expWait;

  always #5 clk = ~clk;

  ctr_multicycle #(.ALUOP_W(2), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .memAck(memAck),
    .memReq(memReq), .memRead(memRead), .memWrite(memWrite), .iorD(iorD),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluop(aluop), .regDst(regDst),
    .memToReg(memToReg), .regWrite(regWrite), .instrDone(instrDone),
    .illegalOp(illegalOp), .memTimeout(memTimeout), .instrCount(instrCount)
  );

  wire [18:0] obs = {memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
                     pcSrc, aluSrcA, aluSrcB, aluop, regDst, memToReg, regWrite,
                     instrDone, illegalOp};

  // Expected control outputs for one cycle of the given step.
  function automatic logic [18:0] expv(int st, logic ack, logic [5:0] lop);
    logic mRd, mWr, iord, irw, pcw, pcwc, asa, rdst, m2r, rw, done, ill;
    logic [1:0] pcs, asb, aop;
    {mRd, mWr, iord, irw, pcw, pcwc, asa, rdst, m2r, rw, done, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      T_FETCH:   begin mRd = 1; asb = 2'b01; irw = ack; pcw = ack; end
      T_DECODE:  asb = 2'b11;
      T_MEMADR:  begin asa = 1; asb = 2'b10; end
      T_MEMRD:   begin mRd = 1; iord = 1; end
      T_MEMWB:   begin m2r = 1; rw = 1; done = 1; end
      T_MEMWR:   begin mWr = 1; iord = 1; done = ack; end
      T_EXEC:    begin asa = 1; aop = 2'b10; end
      T_RWB:     begin rdst = 1; rw = 1; done = 1; end
      T_BRANCH:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      T_JUMP:    begin pcw = 1; pcs = 2'b10; done = 1; end
      T_ILLEGAL: ill = 1;
      T_IEXEC:   begin asa = 1; asb = 2'b10; aop = (lop == 6'b001101) ? 2'b11 : 2'b00; end
      T_IWB:     begin rw = 1; done = 1; end
      default:   ;
    endcase
    return {mRd | mWr, mRd, mWr, iord, irw, pcw, pcwc, pcs, asa, asb, aop,
            rdst, m2r, rw, done, ill};
  endfunction

  task automatic modelReset();
    expCnt  = '0;
    expTmo  = 1'b0;
    expWait = 0;
  endtask

  // One FSM cycle: push expectation, drive inputs at negedge, compare, update model.
  task automatic run(int st, logic ack, logic [5:0] op);
    exp_t e;
    e.ctl = expv(st, ack, op);
    e.cnt = expCnt;
    e.tmo = expTmo;
    sb.push_back(e);

    @(negedge clk);
    memAck = ack;
    opCode = op;
    #1;
    cycNo++;
    e = sb.pop_front();
    total++;
    assert (obs === e.ctl) else begin
      bad++;
      $error("FAIL ctl cyc=%0d step=%0d got=%h exp=%h", cycNo, st, obs, e.ctl);
    end
    total++;
    assert (instrCount === e.cnt) else begin
      bad++;
      $error("FAIL cnt cyc=%0d step=%0d got=%0d exp=%0d", cycNo, st, instrCount, e.cnt);
    end
    total++;
    assert (memTimeout === e.tmo) else begin
      bad++;
      $error("FAIL tmo cyc=%0d step=%0d got=%b exp=%b", cycNo, st, memTimeout, e.tmo);
    end

    if (e.ctl[1]) expCnt = expCnt + 1'b1;
    if ((st == T_FETCH || st == T_MEMRD || st == T_MEMWR) && !ack) begin
      if (expWait == TO - 1) begin
        expTmo  = 1'b1;
        expWait = 0;
      end else begin
        expWait++;
      end
    end else begin
      expWait = 0;
    end
  endtask

  task automatic resetCycle();
    reset = 1'b1;
    modelReset();
    run(T_IDLE, 1'b0, 6'b000000);
    reset = 1'b0;
  endtask

  task automatic jInstr();
    run(T_FETCH,  1'b1, 6'b000010);
    run(T_DECODE, 1'b1, 6'b000010);
    run(T_JUMP,   1'b1, 6'b000010);
  endtask

  initial begin
    reset  = 1'b1;
    memAck = 1'b0;
    opCode = 6'b000000;
    modelReset();
    repeat (3) @(posedge clk);

    // Reset state, released after this IDLE cycle.
    run(T_IDLE, 1'b1, 6'b000000);
    reset = 1'b0;

    // R-type: retire on the 5th cycle counting IDLE.
    run(T_FETCH,  1'b1, 6'b000000);
    run(T_DECODE, 1'b1, 6'b000000);
    run(T_EXEC,   1'b1, 6'b000000);
    run(T_RWB,    1'b1, 6'b000000);

    // lw with two wait cycles in MEMRD.
    run(T_FETCH,  1'b1, 6'b100011);
    run(T_DECODE, 1'b1, 6'b100011);
    run(T_MEMADR, 1'b1, 6'b100011);
    run(T_MEMRD,  1'b0, 6'b100011);
    run(T_MEMRD,  1'b0, 6'b100011);
    run(T_MEMRD,  1'b1, 6'b100011);
    run(T_MEMWB,  1'b1, 6'b100011);

    // beq then j; counter wraps 3 -> 0 on the jump.
    run(T_FETCH,  1'b1, 6'b000100);
    run(T_DECODE, 1'b1, 6'b000100);
    run(T_BRANCH, 1'b1, 6'b000100);
    jInstr();

    // sw with one wait cycle in MEMWR.
    run(T_FETCH,  1'b1, 6'b101011);
    run(T_DECODE, 1'b1, 6'b101011);
    run(T_MEMADR, 1'b1, 6'b101011);
    run(T_MEMWR,  1'b0, 6'b101011);
    run(T_MEMWR,  1'b1, 6'b101011);

    // Unsupported opcode.
    run(T_FETCH,   1'b1, 6'b111111);
    run(T_DECODE,  1'b1, 6'b111111);
    run(T_ILLEGAL, 1'b1, 6'b111111);

    // Immediate opcodes.
    run(T_FETCH,  1'b1, 6'b001101);
    run(T_DECODE, 1'b1, 6'b001101);
`ifdef CTR_IMM_EN
    run(T_IEXEC,  1'b1, 6'b001101);
    run(T_IWB,    1'b1, 6'b001101);
`else
    run(T_ILLEGAL, 1'b1, 6'b001101);
`endif
    run(T_FETCH,  1'b1, 6'b001000);
    run(T_DECODE, 1'b1, 6'b001000);
`ifdef CTR_IMM_EN
    run(T_IEXEC,  1'b1, 6'b001000);
    run(T_IWB,    1'b1, 6'b001000);
`else
    run(T_ILLEGAL, 1'b1, 6'b001000);
`endif

    // memAck on the last allowed wait cycle wins over the timeout.
    run(T_FETCH,  1'b0, 6'b000010);
    run(T_FETCH,  1'b0, 6'b000010);
    run(T_FETCH,  1'b0, 6'b000010);
    run(T_FETCH,  1'b1, 6'b000010);
    run(T_DECODE, 1'b1, 6'b000010);
    run(T_JUMP,   1'b1, 6'b000010);

    // Reset mid-instruction abandons it.
    run(T_FETCH,  1'b1, 6'b000000);
    run(T_DECODE, 1'b1, 6'b000000);
    run(T_EXEC,   1'b1, 6'b000000);
    resetCycle();

    // Four jumps from zero: 1, 2, 3, then wrap to 0.
    for (int i = 0; i < 4; i++) jInstr();

    // Fetch timeout after 4 unacknowledged cycles; park in IDLE until reset.
    for (int i = 0; i < TO; i++) run(T_FETCH, 1'b0, 6'b000000);
    run(T_IDLE, 1'b0, 6'b000000);
    run(T_IDLE, 1'b1, 6'b000000);
    run(T_IDLE, 1'b1, 6'b000000);
    resetCycle();

    // Normal operation resumes after reset.
    run(T_FETCH,  1'b1, 6'b000000);
    run(T_DECODE, 1'b1, 6'b000000);
    run(T_EXEC,   1'b1, 6'b000000);
    run(T_RWB,    1'b1, 6'b000000);
    run(T_FETCH,  1'b1, 6'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
